als_spi_responder: RTL and testbench

SPI responder that emulates the PmodALS light-sensor ADC on the slave side of the link. It accepts an 8-bit light sample from local logic and serialises it on sdo in the ADC frame format: 4 leading zeros, 8 data bits MSB first, 4 trailing zeros. The frame is clocked by an external master's cs/sck, which are oversampled on the local clk. It is used as a bench and loopback target for the PmodALS reader and as a sensor stand-in on boards without the Pmod fitted.

---
 rtl/als_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_als_spi_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/als_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : als_spi_responder
// Description : Slave-side SPI responder that stands in for the PmodALS
//               light-sensor ADC. An 8-bit sample from local logic is
//               serialised on sdo as 4 leading zeros, the data MSB first,
//               then trailing zeros. The frame is paced by an external
//               master's cs/sck, which are oversampled on clk (clk must run
//               at least 8x the sck rate).
// Ports       : clk          system clock
//               rst_n        synchronous active-low reset
//               cs           master chip select, active low, async to clk
//               sck          master serial clock, async to clk
//               sample       value to transmit
//               sample_we    capture sample into the hold register
//               sdo          serial data to the master
//               sdo_oe       sdo drive enable (tristate when 0)
//               busy         frame in progress
//               frame_done   one-cycle pulse on a completed frame
//               frame_abort  one-cycle pulse when cs rises mid-frame
// Revision    : 1.0 - initial release
// ============================================================================
module als_spi_responder #(
    parameter int DATA_W     = 8,
    parameter int LEAD_ZEROS = 4,
    parameter int FRAME_LEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sck,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_we,
    output logic              sdo,
    output logic              sdo_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort
);

    // One spare bit so the counter can hold FRAME_LEN without wrapping.
    localparam int CNT_W = $clog2(FRAME_LEN) + 1;

    localparam logic [CNT_W-1:0] c_data_first = CNT_W'(LEAD_ZEROS);
    localparam logic [CNT_W-1:0] c_data_end   = CNT_W'(LEAD_ZEROS + DATA_W);
    localparam logic [CNT_W-1:0] c_last_edge  = CNT_W'(FRAME_LEN - 1);

    localparam logic [1:0] c_st_arm   = 2'd0;
    localparam logic [1:0] c_st_idle  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    generate
        if (FRAME_LEN < LEAD_ZEROS + DATA_W) begin : g_bad_frame_len
            $error("FRAME_LEN must be at least LEAD_ZEROS + DATA_W");
        end
    endgenerate

    // [0],[1] form the 2-FF synchroniser, [2] is the edge-detect history.
    logic [2:0]        r_cs_sync;
    logic [2:0]        r_sck_sync;
    logic [1:0]        r_state;
    logic [1:0]        r_arm_cnt;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_sdo;
    logic              r_sdo_oe;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_frame_abort;

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_in_data;

    assign w_cs_fall  =  r_cs_sync[2]  & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_sync[2]  &  r_cs_sync[1];
    assign w_sck_rise = ~r_sck_sync[2] &  r_sck_sync[1];
    assign w_sck_fall =  r_sck_sync[2] & ~r_sck_sync[1];

    // True while the bit the master samples on the next rising edge
    // (index r_bit_cnt) is a data bit rather than a padding zero.
    assign w_in_data = (r_bit_cnt >= c_data_first) && (r_bit_cnt < c_data_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs_sync     <= 3'b111;
            r_sck_sync    <= 3'b111;
            r_state       <= c_st_arm;
            r_arm_cnt     <= 2'd0;
            r_hold        <= '0;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_sdo         <= 1'b0;
            r_sdo_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_cs_sync     <= {r_cs_sync[1:0], cs};
            r_sck_sync    <= {r_sck_sync[1:0], sck};
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;

            // The hold register is free-running; a write coinciding with
            // frame start lands after the shift register has loaded.
            if (sample_we) begin
                r_hold <= sample;
            end

            case (r_state)
                c_st_arm: begin
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b0;
                    // The synchroniser resets to 1, which says nothing
                    // about the pin. Let it fill with real samples before
                    // trusting a high cs, so a cs held low through reset
                    // cannot produce a spurious falling edge in IDLE.
                    if (r_arm_cnt != 2'd3) begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                    end else if (r_cs_sync[1] && r_cs_sync[2]) begin
                        r_state <= c_st_idle;
                    end
                end

                c_st_idle: begin
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b0;
                    if (w_cs_fall) begin
                        r_shreg   <= r_hold;
                        r_bit_cnt <= '0;
                        r_sdo_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= c_st_shift;
                    end
                end

                c_st_shift: begin
                    if (w_cs_rise) begin
                        // cs release wins over a coincident sck edge.
                        r_frame_abort <= 1'b1;
                        r_sdo_oe      <= 1'b0;
                        r_sdo         <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= c_st_idle;
                    end else if (w_sck_rise) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_edge) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_sdo        <= 1'b0;
                            r_state      <= c_st_wait;
                        end
                    end else if (w_sck_fall) begin
                        // Data bits are consumed strictly in order, so a
                        // left-shifting register presents each MSB in turn.
                        if (w_in_data) begin
                            r_sdo   <= r_shreg[DATA_W-1];
                            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                        end else begin
                            r_sdo <= 1'b0;
                        end
                    end
                end

                c_st_wait: begin
                    // Surplus sck edges after a full frame read as zeros.
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b1;
                    if (w_cs_rise) begin
                        r_sdo_oe <= 1'b0;
                        r_state  <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_arm;
                end
            endcase
        end
    end

    assign sdo         = r_sdo;
    assign sdo_oe      = r_sdo_oe;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_als_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_als_spi_responder
// Description : Self-checking bench for als_spi_responder. An SPI master
//               drives cs/sck at clk/16 and records sdo on each rising sck
//               edge; frames are compared with the expected ADC word built
//               from the value held at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_als_spi_responder;

    localparam int DW = 8;
    localparam int LZ = 4;
    localparam int FL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          sck;
    logic [DW-1:0] sample;
    logic          sample_we;
    logic          sdo;
    logic          sdo_oe;
    logic          busy;
    logic          frame_done;
    logic          frame_abort;

    als_spi_responder #(
        .DATA_W     (DW),
        .LEAD_ZEROS (LZ),
        .FRAME_LEN  (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .sck         (sck),
        .sample      (sample),
        .sample_we   (sample_we),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse monitor, sampled on the inactive clock edge.
    int   done_cnt      = 0;
    int   abort_cnt     = 0;
    int   done_busy_bad = 0;
    logic prev_busy     = 1'b0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (!(busy === 1'b0 && prev_busy === 1'b1))
                done_busy_bad <= done_busy_bad + 1;
        end
        if (frame_abort === 1'b1)
            abort_cnt <= abort_cnt + 1;
        prev_busy <= busy;
    end

    // Reference: the value the responder is expected to send next frame.
    logic [DW-1:0] model_hold;

    // Bit k seen by the master = bit (FL-1-k) of the word value<<trailing.
    function automatic logic [31:0] expect_bits(input logic [DW-1:0] v, input int n);
        logic [31:0] e;
        int          word;
        e    = '0;
        word = {24'd0, v};
        word = word << (FL - LZ - DW);
        for (int k = 0; k < n && k < 32; k++)
            if (k < FL) e[k] = ((word >> (FL - 1 - k)) & 1) == 1;
        return e;
    endfunction

    task automatic write_hold(input logic [DW-1:0] v);
        sample    = v;
        sample_we = 1'b1;
        @(negedge clk);
        sample_we = 1'b0;
        model_hold = v;
    endtask

    // One master transaction. Optionally writes a new sample during the
    // high phase after rising edge upd_edge, or in the exact cycle the
    // synchronised cs fall is acted on (collide).
    task automatic master_frame(input int n_edges, input int upd_edge,
                                input logic [DW-1:0] upd_val, input bit collide,
                                input logic [DW-1:0] coll_val,
                                output logic [31:0] got, output int oe_bad,
                                output int oe_off);
        got    = '0;
        oe_bad = 0;
        cs     = 1'b0;
        if (collide) begin
            repeat (2) @(negedge clk);
            sample    = coll_val;
            sample_we = 1'b1;
            @(negedge clk);
            sample_we  = 1'b0;
            model_hold = coll_val;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        for (int k = 0; k < n_edges; k++) begin
            if (sdo_oe !== 1'b1) oe_bad++;
            got[k] = sdo;
            sck    = 1'b1;
            if (k == upd_edge) begin
                @(negedge clk);
                sample    = upd_val;
                sample_we = 1'b1;
                @(negedge clk);
                sample_we  = 1'b0;
                model_hold = upd_val;
                repeat (6) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
        cs     = 1'b1;
        oe_off = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (sdo_oe === 1'b0 && oe_off == 99) oe_off = i;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cs        = 1'b1;
        sck       = 1'b0;
        sample    = '0;
        sample_we = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (sdo !== 1'b0)         begin bad++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        total++; if (sdo_oe !== 1'b0)      begin bad++; $display("FAIL reset_sdo_oe got=%b exp=0", sdo_oe); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL reset_frame_abort got=%b exp=0", frame_abort); end
        rst_n      = 1'b1;
        model_hold = '0;
        repeat (10) @(negedge clk);
    endtask

    // Full frame with the value held at frame start; checks bits and pulses.
    task automatic check_frame(input string name, input int n_edges, input int upd_edge,
                               input logic [DW-1:0] upd_val, input bit collide,
                               input logic [DW-1:0] coll_val);
        logic [31:0]   got;
        logic [31:0]   exp;
        int            oe_bad, oe_off, d0, a0, b0;
        logic [DW-1:0] v;
        v  = model_hold;
        d0 = done_cnt;
        a0 = abort_cnt;
        b0 = done_busy_bad;
        master_frame(n_edges, upd_edge, upd_val, collide, coll_val, got, oe_bad, oe_off);
        repeat (4) @(negedge clk);
        exp = expect_bits(v, n_edges);
        total++; if (got !== exp)
            begin bad++; $display("FAIL %s_bits value=%h got=%h exp=%h", name, v, got, exp); end
        total++; if (done_cnt - d0 != 1)
            begin bad++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt - d0); end
        total++; if (abort_cnt - a0 != 0)
            begin bad++; $display("FAIL %s_abort_count got=%0d exp=0", name, abort_cnt - a0); end
        total++; if (done_busy_bad - b0 != 0)
            begin bad++; $display("FAIL %s_busy_with_done got=%0d exp=0", name, done_busy_bad - b0); end
        total++; if (oe_bad != 0 || oe_off > 4)
            begin bad++; $display("FAIL %s_sdo_oe oe_low_edges=%0d off_after=%0d exp 0 and <=4", name, oe_bad, oe_off); end
    endtask

    task automatic test_normal;
        write_hold(8'hA5);
        check_frame("normal", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_mid_update;
        write_hold(8'h3C);
        check_frame("midupd_first", 16, 6, 8'hFF, 1'b0, '0);
        total++; if (model_hold !== 8'hFF)
            begin bad++; $display("FAIL midupd_model got=%h exp=ff", model_hold); end
        check_frame("midupd_next", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_abort;
        logic [31:0] got;
        int          oe_bad, oe_off, d0, a0;
        write_hold(8'h96);
        d0 = done_cnt;
        a0 = abort_cnt;
        master_frame(9, -1, '0, 1'b0, '0, got, oe_bad, oe_off);
        repeat (4) @(negedge clk);
        total++; if (abort_cnt - a0 != 1)
            begin bad++; $display("FAIL abort_count got=%0d exp=1", abort_cnt - a0); end
        total++; if (done_cnt - d0 != 0)
            begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        total++; if (oe_off > 4)
            begin bad++; $display("FAIL abort_oe_off got=%0d exp<=4", oe_off); end
        total++; if (got !== expect_bits(8'h96, 9))
            begin bad++; $display("FAIL abort_partial_bits got=%h exp=%h", got, expect_bits(8'h96, 9)); end
        check_frame("after_abort", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_back_to_back;
        write_hold(8'hD2);
        check_frame("b2b_first", 20, -1, '0, 1'b0, '0);
        write_hold(8'h81);
        check_frame("b2b_second", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_reset_midframe;
        int d0, a0, stray;
        write_hold(8'h5A);
        d0 = done_cnt;
        a0 = abort_cnt;
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            sck = 1'b1; repeat (8) @(negedge clk);
            sck = 1'b0; repeat (8) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({sdo, sdo_oe, busy} !== 3'b000)
            begin bad++; $display("FAIL midreset_outputs got=%b exp=000", {sdo, sdo_oe, busy}); end
        rst_n      = 1'b1;
        model_hold = '0;
        stray      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sdo_oe !== 1'b0 || busy !== 1'b0) stray++;
        end
        total++; if (stray != 0)
            begin bad++; $display("FAIL midreset_no_frame got=%0d active cycles exp=0", stray); end
        total++; if (done_cnt - d0 != 0 || abort_cnt - a0 != 0)
            begin bad++; $display("FAIL midreset_pulses done=%0d abort=%0d exp 0 0", done_cnt - d0, abort_cnt - a0); end
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check_frame("post_reset_hold0", 16, -1, '0, 1'b0, '0);
        write_hold(8'hC3);
        check_frame("post_reset", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_collision;
        write_hold(8'h12);
        check_frame("collide_old", 16, -1, '0, 1'b1, 8'h55);
        total++; if (model_hold !== 8'h55)
            begin bad++; $display("FAIL collide_model got=%h exp=55", model_hold); end
        check_frame("collide_new", 16, -1, '0, 1'b0, '0);
    endtask

    task automatic test_random;
        int            upd;
        logic [DW-1:0] uv;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) write_hold(DW'($urandom));
            upd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
            uv  = DW'($urandom);
            check_frame("random", 16, upd, uv, 1'b0, '0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cs        = 1'b1;
        sck       = 1'b0;
        sample    = '0;
        sample_we = 1'b0;
        model_hold = '0;
        @(negedge clk);
        test_reset;
        test_normal;
        test_mid_update;
        test_abort;
        test_back_to_back;
        test_reset_midframe;
        test_collision;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
